// File: rtl/prog_fetch_ctrl.sv
// Instruction-fetch sequencer for the Nibbler program ROM.
// This module owns the 12-bit program counter and drives the ROM address with it.
// It assembles 1-byte and 2-byte instructions and hands each one to execute
// through a valid/ready handshake.
// Optional build macro PROG_FETCH_STEP_EN adds a `step` input.
// With it, every FETCH waits for a step pulse. The operand byte of a long
// instruction is still fetched without a second pulse.
//
// state         | meaning
// --------------+-----------------------------------------------------------
// FETCH         | latch opcode byte at pc, classify short/long, pc+1
// FETCH_OPERAND | latch second byte at pc, pc+1
// EXECUTE       | instruction presented; wait for exec_ready, apply jump/halt
// HALTED        | fetching stopped, pc frozen; only reset_n leaves this state

module prog_fetch_ctrl #(
    parameter logic [11:0] RESET_VECTOR = 12'h000,
    parameter logic [15:0] LONG_OP_MAP  = 16'h040F
) (
    input  logic        clk,
    input  logic        reset_n,
`ifdef PROG_FETCH_STEP_EN
    input  logic        step,
`endif
    output logic [11:0] rom_addr,
    input  logic [7:0]  rom_data,
    output logic [7:0]  instr,
    output logic [7:0]  operand,
    output logic        instr_long,
    output logic        instr_valid,
    input  logic        exec_ready,
    input  logic        jump_en,
    input  logic [11:0] jump_addr,
    input  logic        halt,
    output logic        halted,
    output logic [11:0] pc_out
);

    typedef enum logic [1:0] {
        FETCH         = 2'd0,
        FETCH_OPERAND = 2'd1,
        EXECUTE       = 2'd2,
        HALTED        = 2'd3
    } state_t;

    state_t      state;
    logic [11:0] pc;
    logic        fetch_go;
    logic        op_is_long;
    logic        accept;

`ifdef PROG_FETCH_STEP_EN
    assign fetch_go = step;
`else
    assign fetch_go = 1'b1;
`endif

    // The ROM is combinational, so the byte at pc is valid in the same cycle.
    assign rom_addr   = pc;
    assign pc_out     = pc;
    assign op_is_long = LONG_OP_MAP[rom_data[7:4]];
    assign accept     = (state == EXECUTE) && exec_ready;

    // Fetch/execute sequencer; every output it drives is registered.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= FETCH;
            pc          <= RESET_VECTOR;
            instr       <= 8'h00;
            operand     <= 8'h00;
            instr_long  <= 1'b0;
            instr_valid <= 1'b0;
            halted      <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    if (fetch_go) begin
                        instr      <= rom_data;
                        instr_long <= op_is_long;
                        pc         <= pc + 12'd1;
                        if (op_is_long) begin
                            state <= FETCH_OPERAND;
                        end else begin
                            state       <= EXECUTE;
                            instr_valid <= 1'b1;
                        end
                    end
                end
                FETCH_OPERAND: begin
                    operand     <= rom_data;
                    pc          <= pc + 12'd1;
                    state       <= EXECUTE;
                    instr_valid <= 1'b1;
                end
                EXECUTE: begin
                    // jump_en and halt only count on the cycle that accepts.
                    if (accept) begin
                        instr_valid <= 1'b0;
                        if (jump_en) begin
                            pc <= jump_addr;
                        end
                        if (halt) begin
                            state  <= HALTED;
                            halted <= 1'b1;
                        end else begin
                            state <= FETCH;
                        end
                    end
                end
                HALTED: begin
                    instr_valid <= 1'b0;
                    halted      <= 1'b1;
                end
                default: begin
                    state <= FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prog_fetch_ctrl.sv
// Bench for prog_fetch_ctrl. Stimulus is randomized.
// A transaction-level model predicts each instruction from the ROM image:
// its bytes, its fetch latency, and the pc after it.
module tb_prog_fetch_ctrl;

    localparam logic [11:0] RV  = 12'h000;
    localparam logic [15:0] MAP = 16'h040F;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [11:0] rom_addr;
    logic [7:0]  rom_data;
    logic [7:0]  instr;
    logic [7:0]  operand;
    logic        instr_long;
    logic        instr_valid;
    logic        exec_ready = 1'b0;
    logic        jump_en = 1'b0;
    logic [11:0] jump_addr = 12'h000;
    logic        halt = 1'b0;
    logic        halted;
    logic [11:0] pc_out;
`ifdef PROG_FETCH_STEP_EN
    logic        step = 1'b1;
`endif

    logic [7:0] rom [4096];
    assign rom_data = rom[rom_addr];

    prog_fetch_ctrl #(.RESET_VECTOR(RV), .LONG_OP_MAP(MAP)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
`ifdef PROG_FETCH_STEP_EN
        .step        (step),
`endif
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .instr       (instr),
        .operand     (operand),
        .instr_long  (instr_long),
        .instr_valid (instr_valid),
        .exec_ready  (exec_ready),
        .jump_en     (jump_en),
        .jump_addr   (jump_addr),
        .halt        (halt),
        .halted      (halted),
        .pc_out      (pc_out)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [11:0] mpc;
    logic [7:0]  mop;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Asynchronous reset in the low clock phase.
    // Values are checked while reset is still held; release lands on a negedge.
    task automatic do_reset();
        #2 reset_n = 1'b0;
        #1;
        check_val("rst_pc", pc_out, RV);
        check_val("rst_addr", rom_addr, RV);
        check_val("rst_instr", instr, 8'h00);
        check_val("rst_operand", operand, 8'h00);
        check_val("rst_long", instr_long, 1'b0);
        check_val("rst_valid", instr_valid, 1'b0);
        check_val("rst_halted", halted, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        mpc = RV;
        mop = 8'h00;
    endtask

    // One instruction: wait for it, check it, optionally stall, then accept with jump/halt or reset mid-EXECUTE.
    task automatic run_instr(input int stalls, input bit jmp, input logic [11:0] addr,
                             input bit hlt, input bit rst_mid);
        logic [7:0]  op;
        logic [7:0]  opd;
        logic [11:0] nxt;
        bit          lng;
        int          cyc;
        op  = rom[mpc];
        nxt = mpc + 12'd1;
        lng = MAP[op[7:4]];
        opd = lng ? rom[nxt] : mop;
        cyc = 0;
        while (instr_valid !== 1'b1 && cyc < 8) begin
            @(negedge clk);
            cyc++;
        end
        check_val("latency", cyc, lng ? 2 : 1);
        mpc = lng ? (mpc + 12'd2) : nxt;
        mop = opd;
        check_val("valid", instr_valid, 1'b1);
        check_val("instr", instr, op);
        check_val("operand", operand, opd);
        check_val("long", instr_long, lng);
        check_val("pc", pc_out, mpc);
        check_val("rom_addr", rom_addr, mpc);
        for (int i = 0; i < stalls; i++) begin
            exec_ready = 1'b0;
            jump_en    = 1'($urandom);
            halt       = 1'($urandom);
            jump_addr  = 12'($urandom);
            @(negedge clk);
            check_val("stall_valid", instr_valid, 1'b1);
            check_val("stall_instr", instr, op);
            check_val("stall_operand", operand, opd);
            check_val("stall_pc", pc_out, mpc);
            check_val("stall_halted", halted, 1'b0);
        end
        jump_en = 1'b0;
        halt    = 1'b0;
        if (rst_mid) begin
            do_reset();
            return;
        end
        exec_ready = 1'b1;
        jump_en    = jmp;
        jump_addr  = addr;
        halt       = hlt;
        @(negedge clk);
        exec_ready = 1'b0;
        jump_en    = 1'b0;
        halt       = 1'b0;
        if (jmp) mpc = addr;
        check_val("acc_valid", instr_valid, 1'b0);
        check_val("acc_pc", pc_out, mpc);
        check_val("acc_addr", rom_addr, mpc);
        check_val("acc_halted", halted, hlt);
        if (hlt) begin
            for (int i = 0; i < 4; i++) begin
                exec_ready = 1'($urandom);
                jump_en    = 1'($urandom);
                halt       = 1'($urandom);
                jump_addr  = 12'($urandom);
                @(negedge clk);
                check_val("hlt_halted", halted, 1'b1);
                check_val("hlt_valid", instr_valid, 1'b0);
                check_val("hlt_pc", pc_out, mpc);
            end
            exec_ready = 1'b0;
            jump_en    = 1'b0;
            halt       = 1'b0;
            do_reset();
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 4096; i++) rom[i] = 8'($urandom);
        rom[12'h000] = 8'h5A;
        rom[12'h001] = 8'h61;
        rom[12'h002] = 8'hA1;
        rom[12'h003] = 8'h23;
        rom[12'hFFF] = 8'h0F;
        mpc = RV;
        mop = 8'h00;
        do_reset();

        // Directed walk: short, short, long JMP, then wrap at FFF, then halt with a jump.
        run_instr(0, 1'b0, 12'h000, 1'b0, 1'b0);
        run_instr(0, 1'b0, 12'h000, 1'b0, 1'b0);
        run_instr(5, 1'b1, 12'h123, 1'b0, 1'b0);
        rom[12'h000] = 8'h77;
        run_instr(0, 1'b1, 12'hFFF, 1'b0, 1'b0);
        run_instr(1, 1'b0, 12'h000, 1'b0, 1'b0);
        run_instr(0, 1'b1, 12'h080, 1'b1, 1'b0);
        run_instr(2, 1'b0, 12'h000, 1'b0, 1'b1);

        // Random programs, jumps, stalls, halts and mid-EXECUTE resets.
        for (int i = 0; i < 100; i++) rom[$urandom_range(0, 4095)] = 8'hA0 | 8'($urandom_range(0, 15));
        for (int n = 0; n < 250; n++) begin
            int          st;
            bit          j;
            bit          h;
            bit          r;
            logic [11:0] a;
            st = $urandom_range(0, 3);
            j  = ($urandom_range(0, 3) == 0);
            h  = ($urandom_range(0, 15) == 0);
            r  = ($urandom_range(0, 31) == 0);
            a  = ($urandom_range(0, 7) == 0) ? (12'hFFF - 12'($urandom_range(0, 1))) : 12'($urandom);
            run_instr(st, j, a, h, r);
        end

`ifdef PROG_FETCH_STEP_EN
        // Without a step pulse nothing is fetched. One pulse brings in a whole long instruction.
        step = 1'b0;
        rom[RV] = 8'h0C;
        rom[RV + 12'd1] = 8'h3C;
        do_reset();
        repeat (5) begin
            @(negedge clk);
            check_val("step_idle_pc", pc_out, RV);
            check_val("step_idle_valid", instr_valid, 1'b0);
        end
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        @(negedge clk);
        check_val("step_valid", instr_valid, 1'b1);
        check_val("step_instr", instr, 8'h0C);
        check_val("step_operand", operand, 8'h3C);
        check_val("step_pc", pc_out, RV + 12'd2);
        exec_ready = 1'b1;
        @(negedge clk);
        exec_ready = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check_val("step_hold_valid", instr_valid, 1'b0);
            check_val("step_hold_pc", pc_out, RV + 12'd2);
        end
        step = 1'b1;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/prog_fetch_ctrl.md
Name: prog_fetch_ctrl

Overview:
- Instruction-fetch sequencer for the Nibbler program ROM, which is a combinational 12-bit-address / 8-bit-data memory.
- Owns the 12-bit program counter and drives the ROM address.
- Assembles 1-byte and 2-byte instructions, then presents them to the execute stage with a valid/ready handshake.
- Applies jump targets and halt requests returned by execute.

Parameters:
- RESET_VECTOR, 12'h000, PC value loaded on reset.
- LONG_OP_MAP, 16'h040F, bit n set means opcode nibble n (rom_data[7:4]) carries a second operand byte. Default covers opcodes 0, 1, 2, 3 and 10 (conditional jumps and JMP).

Ports:
- clk  in  1  system clock; all state changes on the rising edge
- reset_n  in  1  asynchronous, active-low reset
- rom_addr  out  12  address to the program ROM; always equals pc
- rom_data  in  8  program byte returned combinationally by the ROM for rom_addr
- instr  out  8  latched opcode byte
- operand  out  8  latched second byte; holds its last value for 1-byte instructions
- instr_long  out  1  high when the latched instr is a 2-byte instruction
- instr_valid  out  1  instruction presented to execute
- exec_ready  in  1  execute stage accepts the presented instruction this cycle
- jump_en  in  1  load pc from jump_addr; sampled only on an accept
- jump_addr  in  12  jump target
- halt  in  1  stop fetching; sampled only on an accept
- halted  out  1  controller is in HALTED
- pc_out  out  12  current pc, for debug

Behaviour:
- Reset (asynchronous assert, synchronous release): pc=RESET_VECTOR, state=FETCH, instr=8'h00, operand=8'h00, instr_long=0, instr_valid=0, halted=0.
- rom_addr = pc at all times. ROM data is consumed in the same cycle the address is driven.
- The controller has four states: FETCH, FETCH_OPERAND, EXECUTE, HALTED.
- FETCH:
  - instr <= rom_data; pc <= pc+1.
  - instr_long <= LONG_OP_MAP[rom_data[7:4]].
  - If the opcode is long, go to FETCH_OPERAND; otherwise go to EXECUTE.
- FETCH_OPERAND: operand <= rom_data; pc <= pc+1; go to EXECUTE.
- EXECUTE:
  - instr_valid=1 (registered, asserted on state entry). instr, operand and pc are held stable while exec_ready=0.
  - Accept means EXECUTE and exec_ready=1. On accept, instr_valid deasserts next cycle.
  - On accept, if jump_en=1 then pc <= jump_addr; otherwise pc holds (already pointing at the next instruction).
  - On accept, the next state is HALTED if halt=1, otherwise FETCH.
  - halt and jump_en together: pc takes jump_addr and the state goes to HALTED.
- HALTED: halted=1, instr_valid=0, pc frozen. Exit only through reset_n.
- jump_en and halt outside an accept cycle are ignored.
- pc arithmetic is 12-bit modulo: 12'hFFF+1 = 12'h000.
- A long instruction whose opcode sits at 12'hFFF fetches its operand from 12'h000.
- Throughput with exec_ready tied high:
  - short instructions: 2 cycles each (FETCH, EXECUTE)
  - long instructions: 3 cycles each (FETCH, FETCH_OPERAND, EXECUTE)
- Reset asserted mid-operation (any state) immediately returns all state to reset values; no partial instruction survives.
- Unused LONG_OP_MAP bits have no effect beyond classification.

Optional Feature:
- Macro: PROG_FETCH_STEP_EN.
- When defined:
  - Adds input port step (1 bit).
  - FETCH performs no action (pc, instr and state held) unless step=1 in that cycle. One step pulse fetches exactly one instruction, including its operand byte without needing a second pulse.
  - EXECUTE and HALTED are unaffected.
- When undefined: the step port is absent and FETCH always proceeds.

Test Plan:
- ROM bytes 00:8'h5A, 01:8'h61, exec_ready=1 after reset → instr=5A with instr_valid=1 at cycle 2, pc=001; then instr=61 with pc=002 at cycle 4; instr_long=0 both times.
- ROM bytes 00:8'hA1, 01:8'h23 (JMP, long) → instr=A1, operand=23, instr_long=1, instr_valid at cycle 3, pc=002. Accepting with jump_en=1, jump_addr=12'h123 gives rom_addr=123 in the next cycle.
- Hold exec_ready=0 for 5 cycles in EXECUTE → instr_valid stays 1; instr, operand and pc unchanged. jump_en pulses during the stall have no effect.
- Force pc to 12'hFFF through a jump, with byte FFF:8'h0F (long) and 000:8'h77 → operand=77, pc wraps to 12'h001.
- halt=1 and jump_en=1 (jump_addr=12'h080) on accept → halted=1, pc=080, instr_valid=0 for all following cycles. reset_n low mid-EXECUTE → outputs return to reset values asynchronously, pc=RESET_VECTOR.
- With PROG_FETCH_STEP_EN defined and step=0 → pc stays at 000, no instr_valid. A single 1-cycle step pulse on a long opcode → exactly one instruction is presented, operand included.
